// File: rtl/rle_pkg.sv
// Shared types and constants for the JPEG AC run-length symbol packer.
// Symbol field widths track the packer's default RUN_W/COEF_W.
package rle_pkg;

   localparam int unsigned RUN_W_DEF  = 4;
   localparam int unsigned COEF_W_DEF = 8;

   localparam logic [RUN_W_DEF-1:0]  ZRL_RUN   = '1;
   localparam logic [RUN_W_DEF-1:0]  EOB_RUN   = '0;
   localparam logic [COEF_W_DEF-1:0] EOB_VALUE = '0;

   typedef struct packed {
      logic                  eob;
      logic                  last;
      logic [RUN_W_DEF-1:0]  run;
      logic [COEF_W_DEF-1:0] value;
   } sym_t;

   localparam sym_t SYM_EOB = '{eob: 1'b1, last: 1'b1, run: EOB_RUN, value: EOB_VALUE};

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StEobPend
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/rle_lane_prienc.sv
// Masked priority encoder: lowest lane at or above ptr_i holding a nonzero
// coefficient. Lane 0 sits in the MSBs of data_i.
module rle_lane_prienc
   import rle_pkg::*;
#(
   parameter  int unsigned LANES  = 8,
   parameter  int unsigned COEF_W = 8,
   localparam int unsigned IDX_W  = (clog2(LANES) > 0) ? clog2(LANES) : 1
) (
   input  logic [LANES*COEF_W-1:0] data_i,
   input  logic [IDX_W-1:0]        ptr_i,
   output logic                    found_o,
   output logic [IDX_W-1:0]        idx_o
);

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      // Walk from the top so the lowest qualifying lane wins.
      for (int i = int'(LANES) - 1; i >= 0; i--) begin
         if ((i >= int'(ptr_i)) &&
             (data_i[(int'(LANES) - 1 - i) * int'(COEF_W) +: COEF_W] != '0)) begin
            found_o = 1'b1;
            idx_o   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rle_symbol_packer.sv
// Run-length encoder for zigzag-ordered JPEG AC coefficients: one slice of
// LANES coefficients in, one (run, value) / ZRL / EOB symbol out per cycle.
module rle_symbol_packer
   import rle_pkg::*;
#(
   parameter int unsigned LANES     = 8,
   parameter int unsigned COEF_W    = COEF_W_DEF,
   parameter int unsigned RUN_W     = RUN_W_DEF,
   parameter int unsigned BLOCK_LEN = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*COEF_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RUN_W-1:0]        out_run,
   output logic [COEF_W-1:0]       out_value,
   output logic                    out_eob,
   output logic                    out_last
);

   localparam int unsigned IDX_W   = (clog2(LANES) > 0) ? clog2(LANES) : 1;
   localparam int unsigned SLICES  = BLOCK_LEN / LANES;
   localparam int unsigned SIDX_W  = (clog2(SLICES) > 0) ? clog2(SLICES) : 1;
   localparam int unsigned ACC_W   = clog2(BLOCK_LEN) + 1;
   localparam int unsigned RUN_LIM = 2 ** RUN_W;

   state_e                  state_q, state_d;
   logic [LANES*COEF_W-1:0] slice_q, slice_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [SIDX_W-1:0]       sidx_q, sidx_d;
   logic                    out_valid_q, out_valid_d;
   sym_t                    sym_q, sym_d;

   logic                    found;
   logic [IDX_W-1:0]        idx;
   logic [COEF_W-1:0]       lane [LANES];
   logic [ACC_W-1:0]        z;
   logic [ACC_W-1:0]        rest;
   logic                    out_free;
   logic                    accept;
   logic                    drop_slice;
   logic                    last_slice;

   for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
      assign lane[g] = slice_q[(int'(LANES) - 1 - g) * int'(COEF_W) +: COEF_W];
   end

   rle_lane_prienc #(
      .LANES  (LANES),
      .COEF_W (COEF_W)
   ) u_prienc (
      .data_i  (slice_q),
      .ptr_i   (ptr_q),
      .found_o (found),
      .idx_o   (idx)
   );

   assign out_free   = !out_valid_q || out_ready;
   assign in_ready   = (state_q == StIdle) || ((state_q == StEobPend) && out_free);
   assign accept     = in_valid && in_ready;
   assign last_slice = (sidx_q == SIDX_W'(SLICES - 1));

   always_comb begin
      state_d     = state_q;
      slice_d     = slice_q;
      ptr_d       = ptr_q;
      acc_d       = acc_q;
      sidx_d      = sidx_q;
      out_valid_d = out_valid_q;
      sym_d       = sym_q;
      drop_slice  = 1'b0;
      z           = acc_q + ACC_W'(idx) - ACC_W'(ptr_q);
      rest        = ACC_W'(LANES) - ACC_W'(ptr_q);

      if (out_free) out_valid_d = 1'b0;

      unique case (state_q)
         StIdle: ;
         StScan: begin
            if (out_free) begin
               if (!found) begin
                  acc_d      = acc_q + rest;
                  drop_slice = 1'b1;
               end else if (z >= ACC_W'(RUN_LIM)) begin
                  // ZRL leaves the coefficient at idx for a later cycle.
                  out_valid_d = 1'b1;
                  sym_d       = '{eob: 1'b0, last: 1'b0, run: ZRL_RUN, value: '0};
                  acc_d       = z - ACC_W'(RUN_LIM);
                  ptr_d       = idx;
               end else begin
                  out_valid_d = 1'b1;
                  sym_d       = '{eob: 1'b0, last: 1'b0, run: z[RUN_W-1:0], value: lane[idx]};
                  acc_d       = '0;
                  ptr_d       = idx + IDX_W'(1);
                  drop_slice  = (idx == IDX_W'(LANES - 1));
               end

               if (drop_slice) begin
                  ptr_d   = '0;
                  state_d = StIdle;
                  sidx_d  = last_slice ? '0 : sidx_q + SIDX_W'(1);
                  if (last_slice) begin
                     // Trailing zeros become EOB; otherwise the symbol just built ends the block.
                     if (acc_d != '0) state_d = StEobPend;
                     else sym_d.last = 1'b1;
                     acc_d = '0;
                  end
               end
            end
         end
         StEobPend: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               sym_d       = SYM_EOB;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         slice_d = in_data;
         ptr_d   = '0;
         state_d = StScan;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         slice_q     <= '0;
         ptr_q       <= '0;
         acc_q       <= '0;
         sidx_q      <= '0;
         out_valid_q <= 1'b0;
         sym_q       <= '0;
      end else begin
         state_q     <= state_d;
         slice_q     <= slice_d;
         ptr_q       <= ptr_d;
         acc_q       <= acc_d;
         sidx_q      <= sidx_d;
         out_valid_q <= out_valid_d;
         sym_q       <= sym_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_run   = sym_q.run;
   assign out_value = sym_q.value;
   assign out_eob   = sym_q.eob;
   assign out_last  = sym_q.last;

endmodule
